// File: rtl/spi_slave_axis_if_pkg.sv
// Shared types, constants and bit-order helpers for the SPI responder.
package spi_slave_axis_if_pkg;

   typedef logic [7:0] byte_t;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_SELECTED = 1'b1
   } state_t;

   // clk must run at least this many times faster than spi_clk
   localparam int unsigned SPI_SLAVE_MIN_OVERSAMPLE = 8;
   localparam int unsigned SPI_SLAVE_MIN_SYNC       = 2;

   // Bit that leaves the shifter first for the chosen bit order.
   function automatic logic first_bit(input byte_t b, input logic msb_first);
      return msb_first ? b[7] : b[0];
   endfunction

   // Advance a TX shifter by one bit position.
   function automatic byte_t shift_out(input byte_t b, input logic msb_first);
      return msb_first ? {b[6:0], 1'b0} : {1'b0, b[7:1]};
   endfunction

   // Append one received bit to an RX shifter.
   function automatic byte_t shift_in(input byte_t b, input logic bit_in, input logic msb_first);
      return msb_first ? {b[6:0], bit_in} : {bit_in, b[7:1]};
   endfunction

endpackage

// File: rtl/spi_slave_axis_if_if.sv
// Byte-wide AXI-Stream channel used for both the TX (s_axis) and RX (m_axis) sides.
interface spi_slave_axis_if_if;
   import spi_slave_axis_if_pkg::*;

   byte_t tdata;
   logic  tvalid;
   logic  tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input with rise/fall strobes.
module spi_sync_edge
   import spi_slave_axis_if_pkg::*;
#(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic resn,
   input  logic async_in,
   output logic sync,
   output logic rise,
   output logic fall
);

   localparam int unsigned N = (STAGES < SPI_SLAVE_MIN_SYNC) ? SPI_SLAVE_MIN_SYNC : STAGES;

   logic [N-1:0] chain;
   logic         prev;

   // Synchronizer chain plus one delay flop for edge detection
   always_ff @(posedge clk) begin
      if (!resn) begin
         chain <= '0;
         prev  <= 1'b0;
      end else begin
         chain <= {chain[N-2:0], async_in};
         prev  <= chain[N-1];
      end
   end

   assign sync = chain[N-1];
   assign rise = chain[N-1] & ~prev;
   assign fall = ~chain[N-1] & prev;

endmodule

// File: rtl/spi_slave_axis_if.sv
// Oversampling SPI responder: MOSI bytes to an AXIS master, AXIS slave bytes onto MISO.
module spi_slave_axis_if
   import spi_slave_axis_if_pkg::*;
#(
   parameter bit          MSB_FIRST   = 1'b0,
   parameter byte_t       IDLE_BYTE   = 8'h00,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       resn,
   input  logic                       enable,
   spi_slave_axis_if_if.slave         s_axis,
   spi_slave_axis_if_if.master        m_axis,
   input  logic                       spi_csn,
   input  logic                       spi_clk,
   input  logic                       spi_mosi,
   output logic                       spi_miso,
   output logic                       spi_miso_oe,
   output logic                       rx_overrun,
   output logic                       tx_underrun,
   output logic                       busy
);

   logic   csn_sync, csn_rise, csn_fall_unused;
   logic   sclk_sync_unused, sclk_rise, sclk_fall;
   logic   mosi_sync, mosi_rise_unused, mosi_fall_unused;

   state_t state, next_state;
   logic   armed;
   logic   run;
   logic   [2:0] cnt;
   byte_t  tx_shift, rx_shift, rx_next, tx_byte;
   logic   hold_full;
   byte_t  hold_data;
   byte_t  rx_data;
   logic   rx_valid;
   logic   miso_q;
   logic   sel, leaving, active, rx_done, tx_load, s_ready;

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_csn (
      .clk(clk), .resn(resn), .async_in(spi_csn),
      .sync(csn_sync), .rise(csn_rise), .fall(csn_fall_unused)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk(clk), .resn(resn), .async_in(spi_clk),
      .sync(sclk_sync_unused), .rise(sclk_rise), .fall(sclk_fall)
   );

   // Same depth as spi_clk so the MOSI bit is aligned with the falling strobe
   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
      .clk(clk), .resn(resn), .async_in(spi_mosi),
      .sync(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (!resn) state <= ST_IDLE;
      else       state <= next_state;
   end

   // FSM next-state logic; selection needs csn to have been seen high since reset/abort
   always_comb begin
      next_state = state;
      unique case (state)
         ST_IDLE:     if (enable && !csn_sync && armed) next_state = ST_SELECTED;
         ST_SELECTED: if (!enable || csn_rise || csn_sync) next_state = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy        = (state == ST_SELECTED);
      spi_miso_oe = (state == ST_SELECTED);
   end

   // Arm on csn high, disarm once a transaction has started
   always_ff @(posedge clk) begin
      if (!resn)                    armed <= 1'b0;
      else if (csn_sync)            armed <= 1'b1;
      else if (state == ST_SELECTED) armed <= 1'b0;
   end

   // Strobe qualification and shifter next values
   always_comb begin
      sel     = (state == ST_SELECTED);
      leaving = sel && (next_state == ST_IDLE);
      active  = sel && !leaving;
      rx_next = shift_in(rx_shift, mosi_sync, MSB_FIRST);
      // the completing falling strobe still counts when csn rises in the same clk
      rx_done = sel && sclk_fall && (cnt == 3'd7);
      tx_load = active && sclk_rise && (cnt == 3'd0);
      tx_byte = hold_full ? hold_data : IDLE_BYTE;
      s_ready = enable && !hold_full && run;
   end

   // TX holding register: filled by handshake, emptied by a shifter load
   always_ff @(posedge clk) begin
      if (!resn) begin
         hold_full <= 1'b0;
         hold_data <= '0;
         run       <= 1'b0;
      end else begin
         run <= 1'b1;
         if (s_axis.tvalid && s_ready) begin
            hold_full <= 1'b1;
            hold_data <= s_axis.tdata;
         end else if (tx_load && hold_full) begin
            hold_full <= 1'b0;
         end
      end
   end

   // RX output register with overrun detection
   always_ff @(posedge clk) begin
      if (!resn) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         rx_overrun <= 1'b0;
      end else begin
         rx_overrun <= 1'b0;
         if (rx_done) begin
            if (rx_valid && !m_axis.tready) begin
               rx_overrun <= 1'b1;
            end else begin
               rx_data  <= rx_next;
               rx_valid <= 1'b1;
            end
         end else if (rx_valid && m_axis.tready) begin
            rx_valid <= 1'b0;
         end
      end
   end

   // Bit counter and shifters; abort discards the partial byte
   always_ff @(posedge clk) begin
      if (!resn) begin
         cnt         <= '0;
         tx_shift    <= '0;
         rx_shift    <= '0;
         miso_q      <= 1'b0;
         tx_underrun <= 1'b0;
      end else begin
         tx_underrun <= 1'b0;
         if (!active) begin
            cnt    <= '0;
            miso_q <= 1'b0;
         end else begin
            if (sclk_fall) begin
               rx_shift <= rx_next;
               cnt      <= cnt + 3'd1;
            end
            if (sclk_rise) begin
               if (cnt == 3'd0) begin
                  miso_q      <= first_bit(tx_byte, MSB_FIRST);
                  tx_shift    <= shift_out(tx_byte, MSB_FIRST);
                  tx_underrun <= !hold_full;
               end else begin
                  miso_q   <= first_bit(tx_shift, MSB_FIRST);
                  tx_shift <= shift_out(tx_shift, MSB_FIRST);
               end
            end
         end
      end
   end

   assign spi_miso      = miso_q;
   assign s_axis.tready = s_ready;
   assign m_axis.tdata  = rx_data;
   assign m_axis.tvalid = rx_valid;

endmodule

// File: tb/tb_spi_slave_axis_if.sv
// Self-checking bench: SPI master model driving two responders (LSB-first and MSB-first).
module tb_spi_slave_axis_if;
   import spi_slave_axis_if_pkg::*;

   localparam byte_t       IDLE0 = 8'hE7;
   localparam byte_t       IDLE1 = 8'h5C;
   localparam int unsigned SYNC  = 2;

   int checks   = 0;
   int failures = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic resn0, resn1, enable;
   logic csn0, csn1, sclk, mosi;
   logic miso0, oe0, ovr0, und0, busy0;
   logic miso1, oe1, ovr1, und1, busy1;

   spi_slave_axis_if_if tx0();
   spi_slave_axis_if_if rx0();
   spi_slave_axis_if_if tx1();
   spi_slave_axis_if_if rx1();

   spi_slave_axis_if #(.MSB_FIRST(1'b0), .IDLE_BYTE(IDLE0), .SYNC_STAGES(SYNC)) dut0 (
      .clk(clk), .resn(resn0), .enable(enable), .s_axis(tx0), .m_axis(rx0),
      .spi_csn(csn0), .spi_clk(sclk), .spi_mosi(mosi), .spi_miso(miso0),
      .spi_miso_oe(oe0), .rx_overrun(ovr0), .tx_underrun(und0), .busy(busy0)
   );

   spi_slave_axis_if #(.MSB_FIRST(1'b1), .IDLE_BYTE(IDLE1), .SYNC_STAGES(SYNC)) dut1 (
      .clk(clk), .resn(resn1), .enable(enable), .s_axis(tx1), .m_axis(rx1),
      .spi_csn(csn1), .spi_clk(sclk), .spi_mosi(mosi), .spi_miso(miso1),
      .spi_miso_oe(oe1), .rx_overrun(ovr1), .tx_underrun(und1), .busy(busy1)
   );

   // Monitors: log accepted RX beats and count event pulses
   byte_t       rx_log0 [0:255];
   byte_t       rx_log1 [0:255];
   int unsigned rx_n0 = 0, ovr_n0 = 0, und_n0 = 0;
   int unsigned rx_n1 = 0, ovr_n1 = 0, und_n1 = 0;

   always @(negedge clk) begin
      if (rx0.tvalid && rx0.tready) begin
         rx_log0[rx_n0[7:0]] = rx0.tdata;
         rx_n0++;
      end
      if (ovr0) ovr_n0++;
      if (und0) und_n0++;
      if (rx1.tvalid && rx1.tready) begin
         rx_log1[rx_n1[7:0]] = rx1.tdata;
         rx_n1++;
      end
      if (ovr1) ovr_n1++;
      if (und1) und_n1++;
   end

   task automatic set_rx_ready(input int dev, input logic v);
      @(posedge clk);
      #1;
      if (dev == 0) rx0.tready = v;
      else          rx1.tready = v;
   endtask

   task automatic cs(input int dev, input logic v);
      @(negedge clk);
      if (dev == 0) csn0 = v;
      else          csn1 = v;
      repeat (10) @(negedge clk);
   endtask

   // One SPI byte; the master uses the same bit order as the addressed device
   task automatic spi_byte(input int dev, input byte_t mo, output byte_t mi);
      int idx;
      mi = '0;
      for (int k = 0; k < 8; k++) begin
         idx  = (dev == 1) ? 7 - k : k;
         sclk = 1'b1;
         mosi = mo[idx];
         #50;
         sclk = 1'b0;
         mi[idx] = (dev == 0) ? miso0 : miso1;
         #50;
      end
   endtask

   // Offer one TX byte; ok=0 if never accepted within the budget
   task automatic push_tx(input int dev, input byte_t d, output bit ok);
      ok = 1'b0;
      @(negedge clk);
      if (dev == 0) begin tx0.tdata = d; tx0.tvalid = 1'b1; end
      else          begin tx1.tdata = d; tx1.tvalid = 1'b1; end
      for (int i = 0; i < 400; i++) begin
         if (((dev == 0) ? tx0.tready : tx1.tready) == 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      if (dev == 0) tx0.tvalid = 1'b0;
      else          tx1.tvalid = 1'b0;
   endtask

   task automatic test_reset();
      logic [14:0] got;
      resn0 = 1'b0; resn1 = 1'b0; enable = 1'b1;
      csn0 = 1'b1; csn1 = 1'b1; sclk = 1'b0; mosi = 1'b0;
      tx0.tvalid = 1'b0; tx0.tdata = '0; tx1.tvalid = 1'b0; tx1.tdata = '0;
      rx0.tready = 1'b0; rx1.tready = 1'b0;
      repeat (4) @(negedge clk);
      got = {miso0, oe0, tx0.tready, rx0.tvalid, rx0.tdata, ovr0, und0, busy0};
      checks++;
      if (got !== 15'd0) begin failures++; $display("FAIL reset_dut0 got=%h exp=0", got); end
      got = {miso1, oe1, tx1.tready, rx1.tvalid, rx1.tdata, ovr1, und1, busy1};
      checks++;
      if (got !== 15'd0) begin failures++; $display("FAIL reset_dut1 got=%h exp=0", got); end
      @(negedge clk);
      resn0 = 1'b1; resn1 = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (tx0.tready !== 1'b1) begin failures++; $display("FAIL tready_after_reset got=%b exp=1", tx0.tready); end
   endtask

   task automatic test_single();
      byte_t mi, exp_mi;
      byte_t txq[$];
      int unsigned b_rx = rx_n0, b_un = und_n0, b_ov = ovr_n0;
      bit ok;
      set_rx_ready(0, 1'b1);
      push_tx(0, 8'h3C, ok);
      txq.push_back(8'h3C);
      checks++;
      if (!ok) begin failures++; $display("FAIL single_push timeout got=0 exp=1"); end
      cs(0, 1'b0);
      spi_byte(0, 8'hA5, mi);
      cs(0, 1'b1);
      exp_mi = (txq.size() > 0) ? txq.pop_front() : IDLE0;
      checks++;
      if (mi !== exp_mi) begin failures++; $display("FAIL single_miso got=%h exp=%h", mi, exp_mi); end
      checks++;
      if (rx_n0 - b_rx !== 1) begin failures++; $display("FAIL single_beats got=%0d exp=1", rx_n0 - b_rx); end
      checks++;
      if (rx_log0[b_rx[7:0]] !== 8'hA5) begin failures++; $display("FAIL single_rx got=%h exp=a5", rx_log0[b_rx[7:0]]); end
      checks++;
      if ((und_n0 - b_un) !== 0 || (ovr_n0 - b_ov) !== 0) begin
         failures++; $display("FAIL single_flags got und=%0d ovr=%0d exp=0", und_n0 - b_un, ovr_n0 - b_ov);
      end
   endtask

   task automatic test_back_to_back();
      byte_t mo [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      byte_t tv [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
      byte_t mi [4];
      byte_t txq[$];
      byte_t exp_mi;
      int unsigned b_rx = rx_n0, b_un = und_n0, b_ov = ovr_n0;
      int push_fail = 0;
      for (int i = 0; i < 4; i++) txq.push_back(tv[i]);
      fork
         begin
            bit ok;
            for (int i = 0; i < 4; i++) begin
               push_tx(0, tv[i], ok);
               if (!ok) push_fail++;
            end
         end
         begin
            cs(0, 1'b0);
            for (int i = 0; i < 4; i++) spi_byte(0, mo[i], mi[i]);
            cs(0, 1'b1);
         end
      join
      checks++;
      if (push_fail != 0) begin failures++; $display("FAIL b2b_push timeouts got=%0d exp=0", push_fail); end
      checks++;
      if (rx_n0 - b_rx !== 4) begin failures++; $display("FAIL b2b_beats got=%0d exp=4", rx_n0 - b_rx); end
      for (int i = 0; i < 4; i++) begin
         int unsigned j = b_rx + i;
         exp_mi = (txq.size() > 0) ? txq.pop_front() : IDLE0;
         checks++;
         if (mi[i] !== exp_mi) begin failures++; $display("FAIL b2b_miso[%0d] got=%h exp=%h", i, mi[i], exp_mi); end
         checks++;
         if (rx_log0[j[7:0]] !== mo[i]) begin failures++; $display("FAIL b2b_rx[%0d] got=%h exp=%h", i, rx_log0[j[7:0]], mo[i]); end
      end
      checks++;
      if ((und_n0 - b_un) !== 0 || (ovr_n0 - b_ov) !== 0) begin
         failures++; $display("FAIL b2b_flags got und=%0d ovr=%0d exp=0", und_n0 - b_un, ovr_n0 - b_ov);
      end
   endtask

   task automatic test_tx_empty();
      byte_t mo [2];
      byte_t mi [2];
      int unsigned b_rx = rx_n0, b_un = und_n0;
      for (int i = 0; i < 2; i++) mo[i] = byte_t'($urandom);
      cs(0, 1'b0);
      for (int i = 0; i < 2; i++) spi_byte(0, mo[i], mi[i]);
      cs(0, 1'b1);
      for (int i = 0; i < 2; i++) begin
         int unsigned j = b_rx + i;
         checks++;
         if (mi[i] !== IDLE0) begin failures++; $display("FAIL empty_miso[%0d] got=%h exp=%h", i, mi[i], IDLE0); end
         checks++;
         if (rx_log0[j[7:0]] !== mo[i]) begin failures++; $display("FAIL empty_rx[%0d] got=%h exp=%h", i, rx_log0[j[7:0]], mo[i]); end
      end
      checks++;
      if (und_n0 - b_un !== 2) begin failures++; $display("FAIL empty_underrun got=%0d exp=2", und_n0 - b_un); end
   endtask

   task automatic test_backpressure();
      byte_t mo [3];
      byte_t mi;
      int unsigned b_rx, b_ov;
      for (int i = 0; i < 3; i++) mo[i] = byte_t'($urandom);
      set_rx_ready(0, 1'b0);
      b_rx = rx_n0; b_ov = ovr_n0;
      cs(0, 1'b0);
      for (int i = 0; i < 3; i++) spi_byte(0, mo[i], mi);
      cs(0, 1'b1);
      checks++;
      if (rx0.tvalid !== 1'b1 || rx0.tdata !== mo[0]) begin
         failures++; $display("FAIL bp_hold got v=%b d=%h exp v=1 d=%h", rx0.tvalid, rx0.tdata, mo[0]);
      end
      checks++;
      if (ovr_n0 - b_ov !== 2) begin failures++; $display("FAIL bp_overrun got=%0d exp=2", ovr_n0 - b_ov); end
      checks++;
      if (rx_n0 - b_rx !== 0) begin failures++; $display("FAIL bp_no_beat got=%0d exp=0", rx_n0 - b_rx); end
      set_rx_ready(0, 1'b1);
      repeat (3) @(negedge clk);
      checks++;
      if (rx_n0 - b_rx !== 1 || rx_log0[b_rx[7:0]] !== mo[0]) begin
         failures++; $display("FAIL bp_release got beats=%0d d=%h exp 1 %h", rx_n0 - b_rx, rx_log0[b_rx[7:0]], mo[0]);
      end
      checks++;
      if (rx0.tvalid !== 1'b0) begin failures++; $display("FAIL bp_clear got=%b exp=0", rx0.tvalid); end
   endtask

   task automatic test_abort();
      byte_t mi, tv;
      int unsigned b_rx = rx_n0, b_ov = ovr_n0;
      int drop_clk = -1;
      bit ok;
      cs(0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         sclk = 1'b1; mosi = 1'($urandom); #50;
         sclk = 1'b0; #50;
      end
      @(negedge clk);
      csn0 = 1'b1;
      for (int i = 1; i <= int'(SYNC) + 2; i++) begin
         @(negedge clk);
         if (oe0 == 1'b0 && drop_clk < 0) drop_clk = i;
      end
      checks++;
      if (drop_clk < 0) begin failures++; $display("FAIL abort_oe got=1 exp=0 within %0d clk", SYNC + 2); end
      checks++;
      if (miso0 !== 1'b0 || busy0 !== 1'b0) begin failures++; $display("FAIL abort_idle got miso=%b busy=%b exp 0 0", miso0, busy0); end
      repeat (10) @(negedge clk);
      checks++;
      if (rx_n0 - b_rx !== 0 || ovr_n0 - b_ov !== 0) begin
         failures++; $display("FAIL abort_discard got beats=%0d ovr=%0d exp 0 0", rx_n0 - b_rx, ovr_n0 - b_ov);
      end
      tv = byte_t'($urandom);
      push_tx(0, tv, ok);
      cs(0, 1'b0);
      spi_byte(0, 8'h5A, mi);
      cs(0, 1'b1);
      checks++;
      if (!ok || rx_n0 - b_rx !== 1 || rx_log0[b_rx[7:0]] !== 8'h5A) begin
         failures++; $display("FAIL abort_next_rx got beats=%0d d=%h exp 1 5a", rx_n0 - b_rx, rx_log0[b_rx[7:0]]);
      end
      checks++;
      if (mi !== tv) begin failures++; $display("FAIL abort_next_miso got=%h exp=%h", mi, tv); end
   endtask

   task automatic test_reset_mid();
      byte_t mi, tv, r1;
      logic [14:0] got;
      int unsigned b_rx;
      bit ok;
      tv = byte_t'($urandom);
      r1 = byte_t'($urandom);
      push_tx(1, tv, ok);
      cs(1, 1'b0);
      spi_byte(1, r1, mi);
      checks++;
      if (!ok || mi !== tv) begin failures++; $display("FAIL msb_miso got=%h exp=%h", mi, tv); end
      repeat (6) @(negedge clk);
      checks++;
      if (rx1.tvalid !== 1'b1 || rx1.tdata !== r1) begin
         failures++; $display("FAIL msb_rx got v=%b d=%h exp v=1 d=%h", rx1.tvalid, rx1.tdata, r1);
      end
      for (int k = 0; k < 4; k++) begin
         sclk = 1'b1; mosi = 1'($urandom); #50;
         sclk = 1'b0; #50;
      end
      sclk = 1'b1; #20;
      @(negedge clk);
      resn1 = 1'b0;
      @(negedge clk);
      got = {miso1, oe1, tx1.tready, rx1.tvalid, rx1.tdata, ovr1, und1, busy1};
      checks++;
      if (got !== 15'd0) begin failures++; $display("FAIL midreset_outputs got=%h exp=0", got); end
      resn1 = 1'b1;
      #30; sclk = 1'b0; #50;
      for (int k = 0; k < 8; k++) begin
         sclk = 1'b1; mosi = 1'($urandom); #50;
         sclk = 1'b0; #50;
      end
      checks++;
      if (busy1 !== 1'b0 || rx1.tvalid !== 1'b0) begin
         failures++; $display("FAIL midreset_stay_idle got busy=%b v=%b exp 0 0", busy1, rx1.tvalid);
      end
      cs(1, 1'b1);
      set_rx_ready(1, 1'b1);
      b_rx = rx_n1;
      cs(1, 1'b0);
      spi_byte(1, 8'h81, mi);
      cs(1, 1'b1);
      checks++;
      if (rx_n1 - b_rx !== 1 || rx_log1[b_rx[7:0]] !== 8'h81) begin
         failures++; $display("FAIL midreset_next_rx got beats=%0d d=%h exp 1 81", rx_n1 - b_rx, rx_log1[b_rx[7:0]]);
      end
      checks++;
      if (mi !== IDLE1) begin failures++; $display("FAIL midreset_next_miso got=%h exp=%h", mi, IDLE1); end
   endtask

   task automatic test_random();
      for (int t = 0; t < 3; t++) begin
         byte_t mo [2];
         byte_t tv [2];
         byte_t mi [2];
         byte_t txq[$];
         byte_t exp_mi;
         int k = int'($urandom_range(0, 2));
         int unsigned b_rx = rx_n0, b_un = und_n0;
         int push_fail = 0;
         for (int i = 0; i < 2; i++) begin
            mo[i] = byte_t'($urandom);
            tv[i] = byte_t'($urandom);
            if (i < k) txq.push_back(tv[i]);
         end
         fork
            begin
               bit ok;
               for (int i = 0; i < k; i++) begin
                  push_tx(0, tv[i], ok);
                  if (!ok) push_fail++;
               end
            end
            begin
               cs(0, 1'b0);
               for (int i = 0; i < 2; i++) spi_byte(0, mo[i], mi[i]);
               cs(0, 1'b1);
            end
         join
         for (int i = 0; i < 2; i++) begin
            int unsigned j = b_rx + i;
            exp_mi = (txq.size() > 0) ? txq.pop_front() : IDLE0;
            checks++;
            if (mi[i] !== exp_mi) begin failures++; $display("FAIL rand%0d_miso[%0d] got=%h exp=%h", t, i, mi[i], exp_mi); end
            checks++;
            if (rx_log0[j[7:0]] !== mo[i]) begin failures++; $display("FAIL rand%0d_rx[%0d] got=%h exp=%h", t, i, rx_log0[j[7:0]], mo[i]); end
         end
         checks++;
         if (push_fail != 0 || und_n0 - b_un !== 2 - k) begin
            failures++; $display("FAIL rand%0d_underrun got=%0d exp=%0d", t, und_n0 - b_un, 2 - k);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_tx_empty();
      test_backpressure();
      test_abort();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard stop in case a stimulus task stalls
   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule
